// File: rtl/memtest_cmd_gen.sv
// memtest_cmd_gen: memory-test command stream generator (write sweep, optional fault inject, read-back sweep)
module memtest_cmd_gen #(
    parameter logic [7:0] WR_OP  = 8'h02,
    parameter logic [7:0] RD_OP  = 8'h03,
    parameter logic [7:0] INJ_OP = 8'h80
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] addr_lo,
    input  logic [15:0] addr_hi,
    input  logic [7:0]  pattern,
    // "checker" is a reserved word in SystemVerilog, hence the suffix
    input  logic        checker_en,
    input  logic        inj_en,
    input  logic [15:0] inj_addr,
    input  logic [7:0]  inj_data,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        done,
    output logic        range_err,
    output logic [17:0] cmd_count
);
    typedef enum logic [2:0] {IDLE, WR, INJ, RD, FIN} state_t;
    state_t      state_q, state_d;
    logic [15:0] lo_q, lo_d, hi_q, hi_d, addr_q, addr_d, inj_addr_q, inj_addr_d, nxt;
    logic [7:0]  pat_q, pat_d, inj_data_q, inj_data_d;
    logic        chk_q, chk_d, inj_en_q, inj_en_d, abort_q, abort_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [17:0] cnt_q, cnt_d;
    logic        hs, stop;

    function automatic logic [7:0] wr_data(input logic [7:0] p, input logic c, input logic [15:0] a);
        return p ^ ((c & a[0]) ? 8'hFF : 8'h00);
    endfunction

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign range_err     = err_q;
    assign cmd_count     = cnt_q;

    // Next-state and next-command: the output register is reloaded only on a handshake, so a stalled command stays put
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        pat_d      = pat_q;
        chk_d      = chk_q;
        inj_en_d   = inj_en_q;
        inj_addr_d = inj_addr_q;
        inj_data_d = inj_data_q;
        abort_d    = abort_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        hs         = tvalid_q & m_axis_tready;
        stop       = abort | abort_q;
        nxt        = addr_q + 16'd1;
        cnt_d      = (hs && cnt_q != 18'h3FFFF) ? cnt_q + 18'd1 : cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    lo_d       = addr_lo;
                    hi_d       = addr_hi;
                    pat_d      = pattern;
                    chk_d      = checker_en;
                    inj_en_d   = inj_en;
                    inj_addr_d = inj_addr;
                    inj_data_d = inj_data;
                    abort_d    = 1'b0;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    if (addr_lo <= addr_hi) begin
                        state_d  = WR;
                        addr_d   = addr_lo;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tdata_d  = {WR_OP, addr_lo, wr_data(pattern, checker_en, addr_lo)};
                    end else begin
                        err_d   = 1'b1;
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            WR, INJ, RD: begin
                abort_d = stop;
                if (hs) begin
                    if (stop || (state_q == RD && addr_q == hi_q)) begin
                        state_d  = FIN;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else if (state_q == WR && addr_q != hi_q) begin
                        addr_d  = nxt;
                        tdata_d = {WR_OP, nxt, wr_data(pat_q, chk_q, nxt)};
                    end else if (state_q == WR && inj_en_q) begin
                        state_d = INJ;
                        tdata_d = {INJ_OP, inj_addr_q, inj_data_q};
                    end else if (state_q == RD) begin
                        addr_d  = nxt;
                        tdata_d = {RD_OP, nxt, 8'h00};
                        tlast_d = nxt == hi_q;
                    end else begin
                        state_d = RD;
                        addr_d  = lo_q;
                        tdata_d = {RD_OP, lo_q, 8'h00};
                        tlast_d = lo_q == hi_q;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops tvalid immediately and discards the run
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            addr_q     <= '0;
            pat_q      <= '0;
            chk_q      <= 1'b0;
            inj_en_q   <= 1'b0;
            inj_addr_q <= '0;
            inj_data_q <= '0;
            abort_q    <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            pat_q      <= pat_d;
            chk_q      <= chk_d;
            inj_en_q   <= inj_en_d;
            inj_addr_q <= inj_addr_d;
            inj_data_q <= inj_data_d;
            abort_q    <= abort_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
